// File: rtl/dem_dwa_sel.sv
// Unit-element selector for one sub-group behind the decouple sequence
// generator. It turns a per-group element count into a registered enable
// vector, either rotating with data-weighted averaging (DWA) so element
// usage stays balanced, or as a static thermometer for characterisation.
module dem_dwa_sel #(
  parameter int N  = 3,
  parameter int CW = 2,
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic [CW-1:0] cnt,
  output logic [N-1:0]  sel,
  output logic [PW-1:0] ptr,
  output logic          ovf
);

  // Compare width wide enough for both the raw count and the N constant
  localparam int W = (CW > PW + 1) ? CW : PW + 1;
  localparam logic [W-1:0] NWide = W'(N);
  localparam logic [PW:0]  NPtr  = (PW + 1)'(N);

  // A pointer narrower than the group, or a one-element group, cannot rotate
  if (N < 2 || (2 ** PW) < N) begin : gBadConfig
    $error("dem_dwa_sel: illegal configuration, need N >= 2 and 2**PW >= N");
  end

  logic [N-1:0]  sel_q, sel_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          ovf_q, ovf_d;

  logic [W-1:0]  cntWide;
  logic          cntOver;
  logic [PW:0]   effCnt;
  logic [PW:0]   ptrSum;
  logic [PW:0]   ptrSumMod;
  logic [PW-1:0] ptrWrapped;
  logic [N-1:0]  dwaSel;
  logic [N-1:0]  thermSel;
  int            offset;

  // Saturate the requested count at N and flag when it was out of range
  always_comb begin
    cntWide = W'(cnt);
    cntOver = (cntWide > NWide);
    effCnt  = '0;
    if (cntOver) begin
      effCnt = NPtr;
    end else begin
      effCnt = cntWide[PW:0];
    end
  end

  // Advance the pointer by the count, folding back into 0..N-1 with one subtract
  always_comb begin
    ptrSum    = {1'b0, ptr_q} + effCnt;
    ptrSumMod = ptrSum;
    if (ptrSum >= NPtr) begin
      ptrSumMod = ptrSum - NPtr;
    end
    ptrWrapped = ptrSumMod[PW-1:0];
  end

  // Build both candidate enable patterns: a wrapping window from the pointer, and a thermometer from bit 0
  always_comb begin
    dwaSel   = '0;
    thermSel = '0;
    offset   = 0;
    for (int i = 0; i < N; i++) begin
      offset = i - int'(ptr_q);
      if (offset < 0) begin
        offset = offset + N;
      end
      dwaSel[i]   = (offset < int'(effCnt));
      thermSel[i] = (i < int'(effCnt));
    end
  end

  // Pick the next register values; without a strobe everything holds so the element drive stays stable
  always_comb begin
    sel_d = sel_q;
    ptr_d = ptr_q;
    ovf_d = ovf_q;
    if (en) begin
      ovf_d = ovf_q | cntOver;
      if (mode) begin
        sel_d = thermSel;
        ptr_d = '0;
      end else begin
        sel_d = dwaSel;
        ptr_d = ptrWrapped;
      end
    end
  end

  // State registers; outputs come straight from these flops so sel cannot glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= '0;
      ptr_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
    end
  end

  assign sel = sel_q;
  assign ptr = ptr_q;
  assign ovf = ovf_q;

endmodule
